// File: rtl/debounce_4ch.sv
// Four-channel synchroniser + debouncer with a highest-index-wins press filter.
// Outputs are registered; press/multi pulse for one cycle on a debounced rise.
module debounce_4ch #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] raw_in,
  output logic [3:0] level,
  output logic [3:0] press,
  output logic       multi
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [3:0]       sync1_q, sync2_q;
  logic [3:0]       level_q, level_d;
  logic [3:0]       press_q, press_d;
  logic             multi_q, multi_d;
  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_d [4];
  logic [3:0]       rise;
  logic [2:0]       rise_cnt;

  always_comb begin
    level_d  = level_q;
    press_d  = 4'b0000;
    rise_cnt = 3'd0;
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync2_q[i] == level_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        level_d[i] = sync2_q[i];
        cnt_d[i]   = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end
    end
    rise = level_d & ~level_q;
    // Ascending scan so the highest rising channel is the one left in press_d.
    for (int i = 0; i < 4; i++) begin
      rise_cnt = rise_cnt + {2'b00, rise[i]};
      if (rise[i]) begin
        press_d    = 4'b0000;
        press_d[i] = 1'b1;
      end
    end
    multi_d = (rise_cnt >= 3'd2);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 4'b0000;
      sync2_q <= 4'b0000;
      level_q <= 4'b0000;
      press_q <= 4'b0000;
      multi_q <= 1'b0;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q <= raw_in;
      sync2_q <= sync1_q;
      level_q <= level_d;
      press_q <= press_d;
      multi_q <= multi_d;
      for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign level = level_q;
  assign press = press_q;
  assign multi = multi_q;

endmodule

// File: tb/tb_debounce_4ch.sv
// Randomised + directed bench for debounce_4ch against a window-based reference model.
module tb_debounce_4ch;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] raw_in;
  logic [3:0] level;
  logic [3:0] press;
  logic       multi;

  int n_cmp  = 0;
  int n_fail = 0;

  debounce_4ch #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .raw_in (raw_in),
    .level  (level),
    .press  (press),
    .multi  (multi)
  );

  always #5 clk = ~clk;

  // Reference model: a channel's level flips once its last D synchronised
  // samples (since the last reset) all disagree with the current level.
  logic [3:0] m_s1, m_s2, m_lvl;
  logic [3:0] window[$];
  logic [8:0] exp_q[$];

  always @(posedge clk) begin
    logic [3:0] rise, m_press, one;
    logic       m_multi, all_diff;
    rise    = 4'b0000;
    m_press = 4'b0000;
    m_multi = 1'b0;
    if (!rst_n) begin
      m_s1 = 4'b0000;
      m_s2 = 4'b0000;
      m_lvl = 4'b0000;
      window.delete();
    end else begin
      window.push_back(m_s2);
      if (window.size() > D) void'(window.pop_front());
      for (int i = 0; i < 4; i++) begin
        if (window.size() == D) begin
          all_diff = 1'b1;
          foreach (window[j]) if (window[j][i] == m_lvl[i]) all_diff = 1'b0;
          if (all_diff) begin
            if (!m_lvl[i]) rise[i] = 1'b1;
            m_lvl[i] = ~m_lvl[i];
          end
        end
      end
      for (int i = 0; i < 4; i++) begin
        one = 4'b0001;
        if (rise[i]) m_press = one << i;
      end
      m_multi = ($countones(rise) >= 2);
      m_s2 = m_s1;
      m_s1 = raw_in;
    end
    exp_q.push_back({m_lvl, m_press, m_multi});
  end

  // Monitor: outputs are presented every cycle; compare on the falling edge.
  always @(negedge clk) begin
    logic [8:0] e;
    if (exp_q.size() == 0) begin
      n_cmp++; n_fail++;
      $display("FAIL scoreboard_empty: no expected entry at t=%0t", $time);
    end else begin
      e = exp_q.pop_front();
      n_cmp++;
      if (level !== e[8:5]) begin
        n_fail++;
        $display("FAIL level t=%0t: got %b want %b", $time, level, e[8:5]);
      end
      n_cmp++;
      if (press !== e[4:1]) begin
        n_fail++;
        $display("FAIL press t=%0t: got %b want %b", $time, press, e[4:1]);
      end
      n_cmp++;
      if (multi !== e[0]) begin
        n_fail++;
        $display("FAIL multi t=%0t: got %b want %b", $time, multi, e[0]);
      end
      n_cmp++;
      if ($countones(press) > 1) begin
        n_fail++;
        $display("FAIL press_onehot t=%0t: got %b want at most one bit", $time, press);
      end
    end
  end

  task automatic drive(input logic [3:0] r, input logic rs, input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      raw_in = r;
      rst_n  = rs;
    end
  endtask

  initial begin
    int seg_len;
    raw_in = 4'hF;
    rst_n  = 1'b0;
    drive(4'hF, 1'b0, 2);          // reset held 3 edges with inputs high
    drive(4'h0, 1'b1, 10);
    drive(4'b0100, 1'b1, 12);      // single press latency
    drive(4'h0, 1'b1, 10);
    drive(4'b0010, 1'b1, 3);       // glitch rejected
    drive(4'h0, 1'b1, 10);
    drive(4'b0010, 1'b1, 4);       // minimum accepted pulse
    drive(4'h0, 1'b1, 12);
    drive(4'b1011, 1'b1, 12);      // simultaneous rise
    drive(4'b1010, 1'b1, 5);       // release channel 0
    drive(4'b1011, 1'b1, 12);      // re-press
    drive(4'h0, 1'b1, 12);
    drive(4'b1000, 1'b1, 4);       // reset mid-count
    drive(4'b1000, 1'b0, 1);
    drive(4'b1000, 1'b1, 12);
    drive(4'b0001, 1'b1, 1);       // back-to-back rises on different channels
    drive(4'b0011, 1'b1, 12);
    for (int i = 0; i < 20; i++) drive(i[0] ? 4'b0101 : 4'b1010, 1'b1, 1);
    for (int s = 0; s < 400; s++) begin
      seg_len = $urandom_range(1, 2 * D + 2);
      drive(4'($urandom_range(0, 15)), ($urandom_range(0, 40) != 0), seg_len);
    end
    @(negedge clk);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
